bypass_arbiter: RTL and testbench

BYPASS_ARBITER -- requirements
Module: bypass_arbiter

---
 rtl/std_cache_pkg.sv | 32 +++
 rtl/bypass_arbiter.sv | 152 +++++++++++++++
 tb/tb_bypass_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : std_cache_pkg
// Description : Shared request/response types for the uncached bypass path.
//               bypass_req_t carries one downstream access: request strobe,
//               type, AMO opcode, transaction id, address, write data, write
//               enable, byte enables and size. bypass_rsp_t carries the
//               grant, the read-data valid strobe and the read data.
// Revision    : 1.0 - initial release
// ============================================================================
package std_cache_pkg;

  typedef struct packed {
    logic        req;
    logic [1:0]  reqtype;
    logic [3:0]  amo;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

endpackage
`default_nettype wire

// File: rtl/bypass_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bypass_arbiter
// Description : Round-robin arbiter that funnels NUM_PORTS bypass requesters
//               onto one downstream bypass port, with one transaction in
//               flight at a time (IDLE -> REQ -> RSP -> IDLE).
// Ports       : clk_i        - clock, rising edge
//               rst_ni       - asynchronous active-low reset
//               req_ports_i  - upstream requests, one per port
//               rsp_ports_o  - upstream gnt/valid/rdata, one per port
//               req_o        - downstream request (id = owning port)
//               rsp_i        - downstream gnt/valid/rdata
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_arbiter #(
  parameter int NUM_PORTS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  std_cache_pkg::bypass_req_t [NUM_PORTS-1:0]  req_ports_i,
  output std_cache_pkg::bypass_rsp_t [NUM_PORTS-1:0]  rsp_ports_o,
  output std_cache_pkg::bypass_req_t                  req_o,
  input  std_cache_pkg::bypass_rsp_t                  rsp_i
);

  localparam int c_idx_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [c_idx_w-1:0] c_last_port = c_idx_w'(NUM_PORTS - 1);
  localparam logic [c_idx_w:0]   c_num_ports = (c_idx_w + 1)'(NUM_PORTS);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_rsp  = 2'd2;

  logic [1:0]                 r_state;
  logic [1:0]                 w_next_state;
  logic [c_idx_w-1:0]         r_rr;
  logic [c_idx_w-1:0]         r_owner;
  std_cache_pkg::bypass_req_t r_buf;

  logic                       w_found;
  logic [c_idx_w-1:0]         w_winner;
  logic [c_idx_w:0]           w_cand;
  logic                       w_grant;
  logic                       w_done;

  // Round-robin search starting at r_rr. r_rr and the offset are both below
  // NUM_PORTS, so one conditional subtract is enough for the wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = {1'b0, r_rr} + (c_idx_w + 1)'(k);
      if (w_cand >= c_num_ports) begin
        w_cand = w_cand - c_num_ports;
      end
      if (!w_found && req_ports_i[w_cand[c_idx_w-1:0]].req) begin
        w_found  = 1'b1;
        w_winner = w_cand[c_idx_w-1:0];
      end
    end
  end

  // The grant is combinational from the request lines, so it is gated with
  // the reset to keep every output quiet while reset is held.
  assign w_grant = (r_state == c_st_idle) && w_found && rst_ni;

  // Completion: valid together with the downstream grant, or valid in RSP.
  assign w_done = ((r_state == c_st_req) && rsp_i.gnt && rsp_i.valid) ||
                  ((r_state == c_st_rsp) && rsp_i.valid);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_found) begin
          w_next_state = c_st_req;
        end
      end
      c_st_req: begin
        if (rsp_i.gnt) begin
          w_next_state = rsp_i.valid ? c_st_idle : c_st_rsp;
        end
      end
      c_st_rsp: begin
        if (rsp_i.valid) begin
          w_next_state = c_st_idle;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Request buffer, owner and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr    <= '0;
      r_owner <= '0;
      r_buf   <= '0;
    end else begin
      if (w_grant) begin
        r_buf   <= req_ports_i[w_winner];
        r_owner <= w_winner;
      end
      if (w_done) begin
        r_rr <= (r_owner == c_last_port) ? '0 : r_owner + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    req_o       = '0;
    rsp_ports_o = '0;
    if (r_state == c_st_req) begin
      req_o     = r_buf;
      req_o.req = 1'b1;
      req_o.id  = 4'(r_owner);
    end
    if (w_grant) begin
      rsp_ports_o[w_winner].gnt = 1'b1;
    end
    if (w_done) begin
      rsp_ports_o[r_owner].valid = 1'b1;
      rsp_ports_o[r_owner].rdata = rsp_i.rdata;
    end
  end

`ifndef SYNTHESIS
  // Downstream strobes arriving in the wrong state are ignored by the logic
  // above; flag them so a misbehaving downstream is noticed.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      a_valid_in_idle : assert (!(rsp_i.valid && (r_state == c_st_idle)));
      a_gnt_not_req   : assert (!(rsp_i.gnt && (r_state != c_st_req)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bypass_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bypass_arbiter
// Description : Self-checking bench for bypass_arbiter (NUM_PORTS = 3).
//               Expected grants and upstream responses are queued when the
//               stimulus is applied and consumed by a monitor as the DUT
//               produces them; a downstream model answers requests with
//               programmable grant and valid delays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_arbiter;
  import std_cache_pkg::*;

  localparam int NP = 3;

  logic                    clk;
  logic                    rst_ni;
  bypass_req_t [NP-1:0]    req_ports;
  bypass_rsp_t [NP-1:0]    rsp_ports;
  bypass_req_t             ds_req;
  bypass_rsp_t             ds_rsp;

  bypass_arbiter #(.NUM_PORTS(NP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_ports_i (req_ports),
    .rsp_ports_o (rsp_ports),
    .req_o       (ds_req),
    .rsp_i       (ds_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] port_addr(input int p);
    return 64'h8000_0000 + 64'(p * 16);
  endfunction

  function automatic logic [63:0] port_wdata(input int p);
    return 64'hA5A5_0000_0000_0000 + 64'(p);
  endfunction

  // Downstream read data: chosen so port 1 (addr 0x8000_0010) reads 0xDEADBEEF
  function automatic logic [63:0] ds_data(input logic [63:0] a);
    return {32'h0, a[31:0] ^ 32'h5EAD_BEFF};
  endfunction

  function automatic bypass_req_t make_req(input int p);
    bypass_req_t r;
    r         = '0;
    r.req     = 1'b1;
    r.reqtype = 2'b01;
    r.amo     = 4'h0;
    r.id      = 4'hF;
    r.addr    = port_addr(p);
    r.wdata   = port_wdata(p);
    r.we      = p[0];
    r.be      = 8'hFF;
    r.size    = 2'b11;
    return r;
  endfunction

  // Scoreboard queues
  int          exp_gnt[$];
  int          exp_vport[$];
  logic [63:0] exp_vdata[$];
  int          gnt_cyc[$];
  int          val_cyc[$];

  task automatic expect_txn(input int p);
    exp_gnt.push_back(p);
    exp_vport.push_back(p);
    exp_vdata.push_back(ds_data(port_addr(p)));
  endtask

  // Downstream model
  int          gnt_delay = 0;
  int          val_delay = 1;
  int          ds_phase;
  int          ds_cnt;
  logic [63:0] ds_pend;
  bypass_req_t ds_snap;

  initial begin
    ds_rsp   = '0;
    ds_phase = 0;
    ds_cnt   = 0;
    ds_pend  = '0;
    ds_snap  = '0;
    forever begin
      @(negedge clk);
      #1;
      ds_rsp = '0;
      if (!rst_ni) begin
        ds_phase = 0;
      end else begin
        if (ds_phase == 0 && ds_req.req) begin
          ds_phase = 1;
          ds_cnt   = 0;
          ds_snap  = ds_req;
        end
        if (ds_phase == 1) begin
          if (ds_cnt > 0) check("req_hold", 64'(ds_req === ds_snap), 64'd1);
          if (ds_cnt == gnt_delay) begin
            ds_rsp.gnt = 1'b1;
            check("req_id", 64'(ds_req.id), 64'(ds_req.addr[7:4]));
            check("req_addr_hi", 64'(ds_req.addr[63:8]), 64'h80_0000);
            check("req_wdata", ds_req.wdata, port_wdata(int'(ds_req.addr[7:4])));
            ds_pend = ds_data(ds_req.addr);
            if (val_delay == 0) begin
              ds_rsp.valid = 1'b1;
              ds_rsp.rdata = ds_pend;
              ds_phase     = 0;
            end else begin
              ds_phase = 2;
              ds_cnt   = 0;
            end
          end else begin
            ds_cnt++;
          end
        end else if (ds_phase == 2) begin
          check("req_low_rsp", 64'(ds_req.req), 64'd0);
          ds_cnt++;
          if (ds_cnt == val_delay) begin
            ds_rsp.valid = 1'b1;
            ds_rsp.rdata = ds_pend;
            ds_phase     = 0;
          end
        end
      end
    end
  end

  // Upstream monitor
  int cyc = 0;
  initial begin : mon
    int ng;
    int nv;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      ng = 0;
      nv = 0;
      for (int p = 0; p < NP; p++) begin
        if (rsp_ports[p].gnt) begin
          ng++;
          gnt_cyc.push_back(cyc);
          if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(p), 64'hFFFF);
          else check("gnt_port", 64'(p), 64'(exp_gnt.pop_front()));
        end
        if (rsp_ports[p].valid) begin
          nv++;
          val_cyc.push_back(cyc);
          if (exp_vport.size() == 0) begin
            check("valid_unexpected", 64'(p), 64'hFFFF);
          end else begin
            check("valid_port", 64'(p), 64'(exp_vport.pop_front()));
            check("valid_rdata", rsp_ports[p].rdata, exp_vdata.pop_front());
          end
        end else begin
          check("rdata_idle", rsp_ports[p].rdata, 64'd0);
        end
      end
      check("gnt_onehot", 64'(ng <= 1), 64'd1);
      check("valid_onehot", 64'(nv <= 1), 64'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnts();
    int t;
    t = 0;
    while (exp_gnt.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("gnt_drain", 64'(exp_gnt.size()), 64'd0);
    exp_gnt.delete();
  endtask

  task automatic wait_rsps();
    int t;
    t = 0;
    while (exp_vport.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rsp_drain", 64'(exp_vport.size()), 64'd0);
    exp_vport.delete();
    exp_vdata.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni    = 1'b0;
    req_ports = '0;
    gnt_delay = 0;
    val_delay = 1;
    step(2);
    #2;
    check("rst_req_o", 64'(ds_req === '0), 64'd1);
    check("rst_rsp_ports", 64'(rsp_ports === '0), 64'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    step(1);

    // Fairness: three ports requesting continuously
    gnt_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) expect_txn(p);
    for (int p = 0; p < NP; p++) req_ports[p] = make_req(p);
    wait_gnts();
    req_ports = '0;
    wait_rsps();
    check("fair_ngnt", 64'(gnt_cyc.size()), 64'd6);
    for (int i = 1; i < gnt_cyc.size(); i++)
      check("fair_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd3);
    step(2);

    // Single load on port 1: gnt c0, downstream gnt c1, valid c3
    val_delay = 2;
    gnt_cyc.delete();
    val_cyc.delete();
    expect_txn(1);
    req_ports[1] = make_req(1);
    wait_gnts();
    req_ports = '0;
    wait_rsps();
    check("single_nvalid", 64'(val_cyc.size()), 64'd1);
    if (val_cyc.size() > 0 && gnt_cyc.size() > 0)
      check("single_latency", 64'(val_cyc[0] - gnt_cyc[0]), 64'd3);
    step(2);

    // Wrap-around: pointer at 2, ports 0 and 2 requesting
    val_delay = 1;
    expect_txn(2);
    expect_txn(0);
    req_ports[0] = make_req(0);
    req_ports[2] = make_req(2);
    wait_gnts();
    req_ports = '0;
    wait_rsps();
    step(2);

    // Back-pressure: downstream grant withheld 5 cycles, others wait
    gnt_delay = 5;
    expect_txn(1);
    expect_txn(2);
    req_ports[1] = make_req(1);
    req_ports[2] = make_req(2);
    step(1);
    req_ports[1] = '0;
    step(1);
    req_ports[0] = make_req(0);
    step(2);
    req_ports[0] = '0;
    wait_gnts();
    req_ports = '0;
    wait_rsps();
    gnt_delay = 0;
    step(2);

    // Grant and valid together in REQ: re-arbitration two cycles later
    val_delay = 0;
    gnt_cyc.delete();
    expect_txn(0);
    expect_txn(0);
    req_ports[0] = make_req(0);
    wait_gnts();
    req_ports = '0;
    wait_rsps();
    check("gv_ngnt", 64'(gnt_cyc.size()), 64'd2);
    if (gnt_cyc.size() >= 2)
      check("gv_regrant_gap", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd2);
    step(2);

    // Reset while waiting for downstream valid
    val_delay = 4;
    expect_txn(2);
    req_ports[2] = make_req(2);
    wait_gnts();
    req_ports = '0;
    step(2);
    void'(exp_vport.pop_back());
    void'(exp_vdata.pop_back());
    req_ports[0] = make_req(0);
    req_ports[1] = make_req(1);
    rst_ni = 1'b0;
    #2;
    check("rsp_rst_req_o", 64'(ds_req === '0), 64'd1);
    check("rsp_rst_ports", 64'(rsp_ports === '0), 64'd1);
    @(negedge clk);
    exp_gnt.push_back(0);
    exp_vport.push_back(0);
    exp_vdata.push_back(ds_data(port_addr(0)));
    rst_ni = 1'b1;
    wait_gnts();
    req_ports = '0;
    wait_rsps();
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
